// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store queue with in-order drain and ordered load pass-through; optional macro SB_LOAD_BYPASS_EN
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up_req,
    input  logic        up_wr,
    input  logic [1:0]  up_size,
    input  logic [31:0] up_addr,
    input  logic [31:0] up_wdata,
    input  logic [3:0]  up_wstrb,
    output logic [31:0] up_rdata,
    output logic        up_addr_ok,
    output logic        up_data_ok,
    output logic        dn_req,
    output logic        dn_wr,
    output logic [1:0]  dn_size,
    output logic [31:0] dn_addr,
    output logic [31:0] dn_wdata,
    output logic [3:0]  dn_wstrb,
    input  logic [31:0] dn_rdata,
    input  logic        dn_addr_ok,
    input  logic        dn_data_ok,
    output logic        sb_empty
);

    typedef enum logic [2:0] {IDLE, ST_REQ, ST_WAIT, LD_REQ, LD_WAIT} state_t;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    state_t           state;
    logic [31:0]      mem_addr  [DEPTH];
    logic [31:0]      mem_wdata [DEPTH];
    logic [3:0]       mem_wstrb [DEPTH];
    logic [1:0]       mem_size  [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             st_ack;
    logic             ld_pend;
    logic [31:0]      ld_addr;
    logic [1:0]       ld_size;
    logic             enq;
    logic             deq;
    logic             ld_take;
    logic             ld_done;
    logic             ld_go;

    // Loads block all further upstream traffic; stores only need a free slot.
    assign up_addr_ok = !ld_pend && (up_wr ? (count < FULL_CNT) : 1'b1);
    assign enq        = up_req && up_wr && up_addr_ok;
    assign ld_take    = up_req && !up_wr && up_addr_ok;
    assign deq        = (state == ST_WAIT) && dn_data_ok;
    assign ld_done    = (state == LD_WAIT) && dn_data_ok;

`ifdef SB_LOAD_BYPASS_EN
    logic             ld_conflict;
    logic [PTR_W-1:0] slot_off;

    // A load may go ahead once no live entry (head included while draining) hits its word.
    always_comb begin
        ld_conflict = 1'b0;
        slot_off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - head;
            if (({1'b0, slot_off} < count) && (mem_addr[i][31:2] == ld_addr[31:2]))
                ld_conflict = 1'b1;
        end
    end

    assign ld_go = ld_pend && !ld_conflict;
`else
    assign ld_go = ld_pend && (count == '0);
`endif

    // Queue pointers, occupancy and the one-cycle store acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            st_ack <= 1'b0;
        end else begin
            st_ack <= enq;
            if (enq)
                tail <= tail + PTR_ONE;
            if (deq)
                head <= head + PTR_ONE;
            if (enq && !deq)
                count <= count + CNT_ONE;
            else if (deq && !enq)
                count <= count - CNT_ONE;
        end
    end

    // Entry storage; contents are only meaningful between tail and head so no reset needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_addr[tail]  <= up_addr;
            mem_wdata[tail] <= up_wdata;
            mem_wstrb[tail] <= up_wstrb;
            mem_size[tail]  <= up_size;
        end
    end

    // Downstream sequencer plus the captured-load register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ld_pend <= 1'b0;
            ld_addr <= '0;
            ld_size <= '0;
        end else begin
            if (ld_take) begin
                ld_pend <= 1'b1;
                ld_addr <= up_addr;
                ld_size <= up_size;
            end else if (ld_done) begin
                ld_pend <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (ld_go)
                        state <= LD_REQ;
                    else if (count != '0)
                        state <= ST_REQ;
                end
                ST_REQ:  if (dn_addr_ok) state <= ST_WAIT;
                ST_WAIT: if (dn_data_ok) state <= IDLE;
                LD_REQ:  if (dn_addr_ok) state <= LD_WAIT;
                LD_WAIT: if (dn_data_ok) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Downstream fields come from the load register during a load, else from the head entry.
    always_comb begin
        dn_req = (state == ST_REQ) || (state == LD_REQ);
        dn_wr  = (state == ST_REQ);
        if ((state == LD_REQ) || (state == LD_WAIT)) begin
            dn_addr  = ld_addr;
            dn_size  = ld_size;
            dn_wdata = '0;
            dn_wstrb = 4'b0000;
        end else begin
            dn_addr  = mem_addr[head];
            dn_size  = mem_size[head];
            dn_wdata = mem_wdata[head];
            dn_wstrb = mem_wstrb[head];
        end
    end

    assign up_data_ok = st_ack || ld_done;
    assign up_rdata   = dn_rdata;
    assign sb_empty   = (count == '0) && (state != ST_REQ) && (state != ST_WAIT);

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write queue on the data path, between the CPU-side store-acceleration stage and the dcache.
- Stores are acknowledged upstream one cycle after acceptance and drained to the dcache in order, one transaction at a time.
- Loads are held until ordering against queued stores is safe, then passed through.
- Both sides use the SRAM-like req/addr_ok/data_ok protocol.

Parameters:
- DEPTH, 4, number of store entries (power of two, 2..16).
- PTR_W, $clog2(DEPTH), width of the head/tail pointers.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- up_req  in  1  upstream request
- up_wr  in  1  1 = store, 0 = load
- up_size  in  2  access size
- up_addr  in  32  byte address
- up_wdata  in  32  store data
- up_wstrb  in  4  byte strobes
- up_rdata  out  32  load data
- up_addr_ok  out  1  request accepted
- up_data_ok  out  1  response (store ack or load data)
- dn_req  out  1  downstream request
- dn_wr  out  1  downstream write
- dn_size  out  2  downstream size
- dn_addr  out  32  downstream address
- dn_wdata  out  32  downstream write data
- dn_wstrb  out  4  downstream strobes
- dn_rdata  in  32  downstream read data
- dn_addr_ok  in  1  downstream accept
- dn_data_ok  in  1  downstream response
- sb_empty  out  1  no queued or in-flight stores (for cache ops / sync)

Behaviour:
- Storage:
  - DEPTH entries of {addr, wdata, wstrb, size}, managed as a circular FIFO.
  - head and tail are PTR_W bits and wrap modulo DEPTH.
  - count is PTR_W+1 bits, range 0..DEPTH.
- Load register: ld_pend flag plus {addr, size} of the captured load.
- up_addr_ok = !ld_pend && (up_wr ? count < DEPTH : 1).
  - Based on registered count only; no same-cycle dequeue bypass when full.
- Store handshake (up_req && up_wr && up_addr_ok):
  - Write entry at tail, tail+1, count+1.
  - up_data_ok = 1 on the next cycle (registered st_ack).
- Load handshake (up_req && !up_wr && up_addr_ok): capture into the load register, set ld_pend.
  - No further upstream request is accepted while ld_pend = 1.
- Load issue condition ld_go: ld_pend && count == 0.
- Downstream FSM states: IDLE, ST_REQ, ST_WAIT, LD_REQ, LD_WAIT.
  - IDLE: if ld_go -> LD_REQ; else if count != 0 -> ST_REQ.
  - ST_REQ: dn_req = 1, dn_wr = 1, fields from the head entry, held stable until dn_addr_ok, then -> ST_WAIT.
  - ST_WAIT: on dn_data_ok, head+1, count-1 -> IDLE.
  - LD_REQ: dn_req = 1, dn_wr = 0, fields from the load register, until dn_addr_ok -> LD_WAIT.
  - LD_WAIT: on dn_data_ok, up_data_ok = 1 in the same cycle, up_rdata = dn_rdata, clear ld_pend -> IDLE.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
  - A store ack and a load response cannot coincide: a load is only captured after the store ack cycle, and needs at least 2 further cycles before its response.
- up_rdata is don't-care (drive dn_rdata) when not in LD_WAIT.
- dn_wstrb for loads = 4'b0000.
- sb_empty = (count == 0) && (state is not ST_REQ or ST_WAIT).
- Reset values:
  - state IDLE, count/head/tail 0, ld_pend 0, st_ack 0.
  - Outputs: dn_req = 0, up_data_ok = 0, up_addr_ok = 1, sb_empty = 1.
- Reset mid-transaction: queued stores and any in-flight request are discarded. The downstream stage is reset in the same cycle.

Optional Feature:
- Macro: SB_LOAD_BYPASS_EN.
- Defined:
  - ld_go = ld_pend && no valid entry (including the head in ST_REQ/ST_WAIT) has addr[31:2] == ld_addr[31:2].
  - In IDLE, ld_go takes priority over draining, so non-conflicting loads overtake queued stores.
  - Conflicting loads wait until the matching entries drain.
- Undefined: loads wait for a fully empty buffer; the match comparators are absent.

Test Plan:
- Single store to 0x1000, wdata 0xDEADBEEF, wstrb 4'hF:
  - up_addr_ok = 1 and up_data_ok = 1 the next cycle.
  - dn write to 0x1000 with the same data follows.
  - sb_empty returns to 1 after dn_data_ok.
- Five back-to-back stores (DEPTH 4) with dn_addr_ok held 0:
  - The 5th store sees up_addr_ok = 0.
  - Releasing dn_addr_ok and dn_data_ok drains all stores in order 0,1,2,3,4, with pointer wrap verified.
- Store 0x2000 = 0x11223344, then load 0x2000:
  - The load is not issued downstream until the store's dn_data_ok.
  - up_rdata equals dn_rdata with up_data_ok in the same cycle.
  - No upstream accept during ld_pend.
- With SB_LOAD_BYPASS_EN, stores queued to 0x3000 and 0x3004, then load 0x4000:
  - The load is issued before the stores drain.
  - A load to 0x3004 waits until that entry retires.
- Assert rst while in ST_WAIT with count = 3:
  - The next cycle shows count 0, dn_req = 0, up_addr_ok = 1, up_data_ok = 0, sb_empty = 1.
- Enqueue on the exact cycle of dn_data_ok at count = 2: count stays 2, head and tail each +1.
